spi_controller: RTL and testbench

- SPI mode-0 initiator that serialises 16-bit register frames toward the on-chip SPI register peripheral.
- Frame layout: bit 15 = R/W, bits 14:8 = address, bits 7:0 = data; MSB first.
- Accepts one request at a time over a valid/ready handshake, generates nCS/SCLK/COPI from the system clock, and captures CIPO for read frames.
- Sits between test/config logic and the peripheral pins; loopback-testable against the peripheral.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_controller_if.sv | 22 ++
 rtl/spi_sclk_gen.sv | 53 +++++
 rtl/spi_controller.sv | 159 +++++++++++++++
 tb/tb_spi_controller.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-frame initiator: frame geometry,
// peripheral register map, controller states and a sizing helper.
package spi_pkg;

   localparam int unsigned SPI_FRAME_BITS = 16;
   localparam logic        SPI_RW_WRITE   = 1'b1;

   localparam logic [6:0] EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] PWM_DUTY    = 7'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_t;

   function automatic int unsigned spi_max4(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request/response side of the SPI initiator: valid/ready request plus
// busy/done status and captured read data.
interface spi_controller_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_rw;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       busy;
   logic       done;
   logic [7:0] rdata;

   modport master (
      output req_valid, req_rw, req_addr, req_wdata,
      input  req_ready, busy, done, rdata
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata,
      output req_ready, busy, done, rdata
   );
endinterface

// File: rtl/spi_sclk_gen.sv
// The controller's only down-counter: times SETUP/HOLD/GAP when loaded by the
// FSM and, while shifting, self-reloads each half-period to toggle SCLK.
module spi_sclk_gen #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CNT_W   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             sclk,
   output logic             rise,
   output logic             fall,
   output logic             zero,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] HALF_V = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic             sclk_reg;

   assign zero = (cnt_reg == '0);
   assign rise = shift_en && zero && !sclk_reg;
   assign fall = shift_en && zero && sclk_reg;
   assign sclk = sclk_reg;
   assign cnt  = cnt_reg;

   // An FSM load wins over the half-period reload so the last fall can hand
   // the counter straight to HOLD timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg  <= '0;
         sclk_reg <= 1'b0;
      end else begin
         if (load)
            cnt_reg <= load_val;
         else if (rise || fall)
            cnt_reg <= HALF_V;
         else if (!zero)
            cnt_reg <= cnt_reg - 1'b1;

         if (!shift_en)
            sclk_reg <= 1'b0;
         else if (rise)
            sclk_reg <= 1'b1;
         else if (fall)
            sclk_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises {rw, addr[6:0], data[7:0]} MSB first and
// captures the last eight CIPO bits of read frames into rdata.
module spi_controller
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 4,
   parameter int unsigned CS_HOLD  = 4,
   parameter int unsigned CS_IDLE  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   spi_controller_if.slave        bus,
   output logic                   nCS,
   output logic                   SCLK,
   output logic                   COPI,
   input  logic                   CIPO
);

   localparam int unsigned CNT_MAX = spi_max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] SETUP_V = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HALF_V  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_V   = CNT_W'(CS_IDLE - 1);
   localparam logic [3:0]       LAST_BIT = 4'(SPI_FRAME_BITS - 1);

   spi_state_t                state_reg;
   logic [SPI_FRAME_BITS-1:0] shift_reg;
   logic [7:0]                rx_reg;
   logic [7:0]                rdata_reg;
   logic [3:0]                bit_cnt_reg;
   logic                      rw_reg;
   logic                      ncs_reg;
   logic                      copi_reg;
   logic                      busy_reg;
   logic                      done_reg;
   logic                      ready_reg;

   logic                      accept;
   logic                      shift_en;
   logic                      tmr_load;
   logic [CNT_W-1:0]          tmr_val;
   logic                      tmr_zero;
   logic [CNT_W-1:0]          tmr_cnt;
   logic                      sclk_rise;
   logic                      sclk_fall;
   logic                      last_fall;

   assign accept    = bus.req_valid && ready_reg;
   assign shift_en  = (state_reg == ST_SHIFT);
   assign last_fall = sclk_fall && (bit_cnt_reg == LAST_BIT);

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W)
   ) u_sclk_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .load     (tmr_load),
      .load_val (tmr_val),
      .sclk     (SCLK),
      .rise     (sclk_rise),
      .fall     (sclk_fall),
      .zero     (tmr_zero),
      .cnt      (tmr_cnt)
   );

   // Counter reload on every state change, with the duration of the state being entered.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state_reg)
         ST_IDLE:  if (accept)    begin tmr_load = 1'b1; tmr_val = SETUP_V; end
         ST_SETUP: if (tmr_zero)  begin tmr_load = 1'b1; tmr_val = HALF_V;  end
         ST_SHIFT: if (last_fall) begin tmr_load = 1'b1; tmr_val = HOLD_V;  end
         ST_HOLD:  if (tmr_zero)  begin tmr_load = 1'b1; tmr_val = GAP_V;   end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         shift_reg   <= '0;
         rx_reg      <= '0;
         rdata_reg   <= '0;
         bit_cnt_reg <= '0;
         rw_reg      <= 1'b0;
         ncs_reg     <= 1'b1;
         copi_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         ready_reg   <= 1'b1;
      end else begin
         done_reg <= 1'b0;
         unique case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  shift_reg   <= {bus.req_rw, bus.req_addr, bus.req_wdata};
                  rw_reg      <= bus.req_rw;
                  copi_reg    <= bus.req_rw;
                  ncs_reg     <= 1'b0;
                  busy_reg    <= 1'b1;
                  ready_reg   <= 1'b0;
                  bit_cnt_reg <= '0;
                  state_reg   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tmr_zero)
                  state_reg <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (sclk_rise)
                  rx_reg <= {rx_reg[6:0], CIPO};
               if (last_fall) begin
                  state_reg <= ST_HOLD;
               end else if (sclk_fall) begin
                  shift_reg   <= shift_reg << 1;
                  copi_reg    <= shift_reg[SPI_FRAME_BITS-2];
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
               end
            end
            ST_HOLD: begin
               if (tmr_zero) begin
                  ncs_reg   <= 1'b1;
                  copi_reg  <= 1'b0;
                  state_reg <= ST_GAP;
               end
            end
            ST_GAP: begin
               // done is registered, so raise it one count early to land in the last GAP cycle.
               if (tmr_cnt == CNT_W'(1)) begin
                  done_reg <= 1'b1;
                  if (rw_reg != SPI_RW_WRITE)
                     rdata_reg <= rx_reg;
               end
               if (tmr_zero) begin
                  busy_reg  <= 1'b0;
                  ready_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready = ready_reg;
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.rdata     = rdata_reg;
   assign nCS           = ncs_reg;
   assign COPI          = copi_reg;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: directed and random frames compared
// against a frame-level model of bits, timing and read data.
module tb_spi_controller;
   import spi_pkg::*;

   logic clk;
   logic rst_n;
   logic nCS;
   logic SCLK;
   logic COPI;
   logic CIPO;

   spi_controller_if bus ();

   spi_controller #(
      .CLK_DIV  (4),
      .CS_SETUP (4),
      .CS_HOLD  (4),
      .CS_IDLE  (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .nCS   (nCS),
      .SCLK  (SCLK),
      .COPI  (COPI),
      .CIPO  (CIPO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   pass_cnt = 0;
   int   check_cnt = 0;
   int   txn = 0;
   logic [7:0] model_rdata = 8'h00;

   // Frame-level expectations with the default parameters.
   localparam int EXP_RISES   = 16;
   localparam int EXP_NCS_LOW = 4 + 32 * 4 + 4;
   localparam int EXP_DONE    = 1 + EXP_NCS_LOW + 4 - 1;

   task automatic check_eq(input string tag, input int got, input int exp);
      check_cnt++;
      if (got == exp)
         pass_cnt++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h (time %0t)", tag, got, exp, $time);
   endtask

   task automatic do_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                           input logic [15:0] cipo_word, input bit hold_valid,
                           input bit scramble, input bit expect_b2b);
      int          waits = 0;
      int          cyc = 0;
      int          rises = 0;
      int          ncs_low = 0;
      int          gap = 0;
      int          ready_bad = 0;
      int          done_cyc = -1;
      bit          done_seen = 0;
      logic        prev_sclk;
      logic [15:0] got = 16'h0;
      logic [15:0] exp_frame;
      exp_frame     = {rw, addr, data};
      bus.req_valid = 1'b1;
      bus.req_rw    = rw;
      bus.req_addr  = addr;
      bus.req_wdata = data;
      while (!bus.req_ready && waits < 400) begin
         @(negedge clk);
         waits++;
      end
      if (!bus.req_ready) begin
         check_eq("accept_timeout", 0, 1);
         bus.req_valid = 1'b0;
         return;
      end
      if (expect_b2b)
         check_eq("b2b_wait", waits, 0);
      prev_sclk = SCLK;
      CIPO = cipo_word[15];
      while (!done_seen && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            if (!hold_valid) bus.req_valid = 1'b0;
            check_eq("busy_start", int'(bus.busy), 1);
         end
         if (scramble) begin
            bus.req_addr  = 7'($urandom);
            bus.req_wdata = 8'($urandom);
         end
         if (SCLK && !prev_sclk) begin
            if (rises < 16) got[15 - rises] = COPI;
            rises++;
         end
         prev_sclk = SCLK;
         if (!nCS) ncs_low++;
         else if (ncs_low > 0) gap++;
         if (bus.req_ready) ready_bad++;
         if (bus.done) begin
            done_seen = 1;
            done_cyc  = cyc;
         end
         CIPO = (rises < 16) ? cipo_word[15 - rises] : 1'b0;
      end
      if (!done_seen) begin
         check_eq("done_timeout", 0, 1);
         return;
      end
      if (rw != SPI_RW_WRITE) model_rdata = cipo_word[7:0];
      check_eq("frame_bits", int'(got), int'(exp_frame));
      check_eq("sclk_rises", rises, EXP_RISES);
      check_eq("ncs_low", ncs_low, EXP_NCS_LOW);
      check_eq("done_cycle", done_cyc, EXP_DONE);
      check_eq("ready_busy", ready_bad, 0);
      check_eq("rdata", int'(bus.rdata), int'(model_rdata));
      @(negedge clk);
      if (nCS) gap++;
      check_eq("done_pulse", int'(bus.done), 0);
      check_eq("ready_idle", int'(bus.req_ready), 1);
      check_eq("busy_end", int'(bus.busy), 0);
      check_eq("gap_min", int'(gap >= 4), 1);
      txn++;
      $display("txn %0d: rw=%0d addr=0x%02h data=0x%02h frame=0x%04h rises=%0d ncs_low=%0d done@%0d rdata=0x%02h",
               txn, rw, addr, data, got, rises, ncs_low, done_cyc, bus.rdata);
   endtask

   task automatic reset_mid_frame();
      int waits = 0;
      int cyc = 0;
      int rises = 0;
      int bad_done = 0;
      logic prev_sclk;
      bus.req_valid = 1'b1;
      bus.req_rw    = SPI_RW_WRITE;
      bus.req_addr  = EN_PWM_7_0;
      bus.req_wdata = 8'h5A;
      while (!bus.req_ready && waits < 400) begin
         @(negedge clk);
         waits++;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      prev_sclk = SCLK;
      while (rises < 7 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (SCLK && !prev_sclk) rises++;
         prev_sclk = SCLK;
      end
      check_eq("rst_mid_rises", rises, 7);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_ncs", int'(nCS), 1);
      check_eq("rst_mid_sclk", int'(SCLK), 0);
      check_eq("rst_mid_busy", int'(bus.busy), 0);
      check_eq("rst_mid_ready", int'(bus.req_ready), 1);
      model_rdata = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.done) bad_done++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.done) bad_done++;
      end
      check_eq("rst_mid_no_done", bad_done, 0);
      check_eq("rst_mid_rdata", int'(bus.rdata), int'(model_rdata));
      txn++;
      $display("txn %0d: reset after %0d SCLK rises, frame abandoned", txn, rises);
   endtask

   initial begin
      int activity;
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  data;
      logic [15:0] cw;
      rst_n         = 1'b0;
      CIPO          = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_rw    = 1'b0;
      bus.req_addr  = 7'h00;
      bus.req_wdata = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_ncs", int'(nCS), 1);
      check_eq("rst_sclk", int'(SCLK), 0);
      check_eq("rst_copi", int'(COPI), 0);
      check_eq("rst_busy", int'(bus.busy), 0);
      check_eq("rst_done", int'(bus.done), 0);
      check_eq("rst_rdata", int'(bus.rdata), 0);
      check_eq("rst_ready", int'(bus.req_ready), 1);
      rst_n = 1'b1;
      activity = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (SCLK || !nCS) activity++;
      end
      check_eq("idle_quiet", activity, 0);

      do_frame(SPI_RW_WRITE, PWM_DUTY, 8'hA5, 16'h0000, 0, 0, 0);
      do_frame(SPI_RW_WRITE, EN_OUT_7_0, 8'hFF, 16'h0000, 1, 0, 0);
      do_frame(SPI_RW_WRITE, EN_OUT_15_8, 8'h0F, 16'h0000, 0, 0, 1);
      do_frame(1'b0, EN_OUT_15_8, 8'h00, 16'h813C, 0, 0, 0);
      do_frame(SPI_RW_WRITE, EN_PWM_15_8, 8'h77, 16'hFFC3, 0, 0, 0);
      do_frame(SPI_RW_WRITE, 7'h2B, 8'hD4, 16'h1234, 0, 1, 0);
      do_frame(1'b0, 7'h55, 8'h99, 16'hABCD, 0, 1, 0);

      for (int i = 0; i < 6; i++) begin
         rw   = 1'($urandom);
         addr = 7'($urandom);
         data = 8'($urandom);
         cw   = 16'($urandom);
         do_frame(rw, addr, data, cw, 0, (i % 2) == 1, 0);
      end

      reset_mid_frame();
      do_frame(SPI_RW_WRITE, EN_PWM_7_0, 8'h3E, 16'h0000, 0, 0, 0);
      do_frame(1'b0, PWM_DUTY, 8'h00, 16'h00E7, 0, 0, 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
